// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions used by the fetch stage: fetch FSM states,
// instruction word width and the default reset PC.
package instr_fetch_pkg;

    localparam int INSTR_W          = 32;
    localparam int RESET_PC_DEFAULT = 0;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake
// and holds the fetched word in the instruction register until consumed.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic [31:0]        instr_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               req_q, req_d;
    logic [31:0]        count_q, count_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        count_d    = count_q;

        // A consume is counted even when halt or redirect wins the cycle.
        if (ir_valid_q && ir_ready) begin
            count_d = count_q + 32'd1;
        end

        if (state_q != HALTED) begin
            if (halt) begin
                state_d    = HALTED;
                ir_valid_d = 1'b0;
            end else if (redirect) begin
                pc_d       = redirect_pc;
                ir_valid_d = 1'b0;
                case (state_q)
                    // Only a request actually on the bus leaves an ack to drain.
                    FETCH:   state_d = (req_q && !imem_ack) ? DRAIN : FETCH;
                    DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
                    default: state_d = FETCH;
                endcase
            end else begin
                case (state_q)
                    FETCH: begin
                        if (imem_ack) begin
                            ir_d       = imem_rdata;
                            ir_pc_d    = pc_q;
                            ir_valid_d = 1'b1;
                            state_d    = HOLD;
                        end
                    end
                    HOLD: begin
                        if (ir_ready) begin
                            ir_valid_d = 1'b0;
                            pc_d       = pc_q + ADDR_W'(1);
                            state_d    = FETCH;
                        end
                    end
                    DRAIN: begin
                        if (imem_ack) begin
                            state_d = FETCH;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end

        // Request is registered so it stays low through reset and the first cycle after.
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            req_q      <= req_d;
            count_q    <= count_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign pc          = pc_q;
    assign instr_count = count_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction Fetch stage of the multi-cycle processor: owns the program counter, requests instruction words from instruction memory over a request/acknowledge handshake, and presents the fetched word in a held instruction register to the combinational decoder. It sits directly upstream of `instr_decode`. It accepts branch/jump redirects and a halt request from the execute stage.

## Interface
- `ADDR_W`, 32: PC and instruction-memory address width. The address is a word address.
- `RESET_PC`, 0: PC value loaded at reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out ADDR_W: word address; equals `pc` whenever `imem_req`=1.
- `imem_rdata` in 32: instruction word; valid only when `imem_ack`=1.
- `imem_ack` in 1: one-cycle response strobe; may arrive in the same cycle as the first `imem_req` cycle or later.
- `ir` out 32: instruction register feeding the decoder.
- `ir_pc` out ADDR_W: address `ir` was fetched from.
- `ir_valid` out 1: `ir` holds a fetched, not-yet-consumed instruction.
- `ir_ready` in 1: downstream consumes `ir` when `ir_valid`=1 in the same cycle.
- `redirect` in 1: one-cycle strobe; load `redirect_pc` as the next fetch address.
- `redirect_pc` in ADDR_W: branch/jump/jr target.
- `halt` in 1: one-cycle strobe from the syscall-exit path.
- `pc` out ADDR_W: current fetch PC.
- `instr_count` out 32: number of instructions consumed; wraps at 2^32.

## Operation
- Reset values: `pc`=RESET_PC, `ir`=0, `ir_pc`=0, `ir_valid`=0, `imem_req`=0, `instr_count`=0, state=FETCH.
- The FSM has four states: FETCH, HOLD, DRAIN, HALTED.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both stable until ack.
  - On `imem_ack`: `ir`<=`imem_rdata`, `ir_pc`<=`pc`, `ir_valid`<=1, go to HOLD.
- HOLD:
  - `imem_req`=0 and `ir` is held.
  - On `ir_ready`: `ir_valid`<=0, `pc`<=`pc`+1 (wrap from 2^ADDR_W-1 to 0), `instr_count`+=1, go to FETCH.
- DRAIN:
  - `imem_req`=0. Entered only on a redirect while a request is outstanding.
  - The next `imem_ack` is discarded, then go to FETCH with the already-loaded redirect `pc`.
- HALTED:
  - `imem_req`=0 and `ir_valid`=0. Sticky until `reset_n` is asserted.
  - `redirect`, `ir_ready` and `imem_ack` are ignored.
- Redirect: in any state except HALTED, `pc`<=`redirect_pc` and `ir_valid`<=0. Next state:
  - FETCH without ack: DRAIN.
  - FETCH with ack in the same cycle: the data is discarded, next state FETCH.
  - HOLD: FETCH. `instr_count` still increments if `ir_ready`=1 in that cycle, but `pc` takes `redirect_pc`, not `pc`+1.
  - DRAIN: stay in DRAIN, with the new target latched.
- Priority: `halt` > `redirect` > `imem_ack`/`ir_ready`.
- Halt: in any state, `ir_valid`<=0 and go to HALTED. `pc` is frozen. An `ir_ready` in the same cycle as a valid `ir` still counts.

## Timing
- Fetch latency: `ir_valid` rises the cycle after `imem_ack`.
- Best case is 2 cycles per instruction: FETCH with same-cycle ack, then HOLD with `ir_ready`.
- `ir`, `ir_pc` and `ir_valid` are registered outputs. `imem_req` and `imem_addr` are decoded from registered state and `pc`, with no combinational path from any input.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending memory response arriving after reset release is treated as a normal ack in FETCH. The memory model must not ack without a live request.

## Structure
- Shared processor package holds:
  - the fetch state enumeration;
  - the `RESET_PC` default;
  - the instruction word width (32).
- Single flat module, no sub-module: the next-PC mux and the FSM are small enough to live together.

## Test plan
- Reset release with RESET_PC=0 and zero-wait memory returning 32'h0000_0001 (add): `imem_req`=1 with addr 0 in cycle 1; `ir`=32'h0000_0001 and `ir_valid`=1 in cycle 2; with `ir_ready` high, addr 1 is requested in cycle 3.
- Memory with 3-cycle ack latency: `imem_req` and `imem_addr` are held stable for all 3 cycles; `ir_valid` asserts exactly one cycle after ack; `ir_ready` held low for 5 cycles keeps `ir` unchanged.
- Redirect to 0x40 while FETCH at addr 5 is outstanding: enter DRAIN; the ack with 32'hDEAD_BEEF is discarded and never appears on `ir`; the next request is at addr 0x40.
- `redirect` (0x10) and `ir_ready` in the same HOLD cycle at pc 7: the next fetch is at 0x10, not 8; `instr_count` increments by 1.
- `halt` during HOLD: `ir_valid` drops the next cycle; no further `imem_req` for 20 cycles despite `redirect` and `ir_ready` pulses; asserting `reset_n` low restores `pc`=RESET_PC and `instr_count`=0.
- PC wrap with ADDR_W=4 and `pc`=15: after consume, the next request is at addr 0.
